// File: rtl/directory_controller.sv
// Directory controller: per-line UNCACHED/SHARED/MODIFIED state plus sharer vector, one request at a time.
// Optional DIR_INV_ACK_EN: the reply waits until every invalidated sharer has returned invAck.
//
//  state  | meaning
//  IDLE   | reqReady high, capture next request
//  LOOKUP | read directory entry, decide message/reply/update
//  SEND   | msgValid held until msgReady
//  WAIT   | wait for fetchDone (FETCH/FETCH_INV) or all invAcks
//  REPLY  | replyValid held until replyReady, entry written on accept
module directory_controller #(
   parameter int NUM_NODES = 4,
   parameter int NUM_LINES = 16,
   localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
   localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 reqValid,
   output logic                 reqReady,
   input  logic [1:0]           reqType,
   input  logic [NODE_W-1:0]    reqNode,
   input  logic [LINE_W-1:0]    reqLine,
   output logic                 msgValid,
   input  logic                 msgReady,
   output logic [1:0]           msgType,
   output logic [NUM_NODES-1:0] msgTargets,
   output logic [LINE_W-1:0]    msgLine,
   input  logic                 fetchDone,
   input  logic                 invAck,
   output logic                 replyValid,
   input  logic                 replyReady,
   output logic [1:0]           replyType,
   output logic [NODE_W-1:0]    replyNode,
   output logic [LINE_W-1:0]    replyLine,
   output logic                 protoError
);

   localparam logic [1:0] RQ_READ = 2'b00, RQ_INV = 2'b10, RQ_WB = 2'b11;
   localparam logic [1:0] MSG_FETCH = 2'b01, MSG_INV = 2'b10, MSG_FETCH_INV = 2'b11;
   localparam logic [1:0] RP_DATA = 2'b01, RP_UPG = 2'b10;
   localparam logic [1:0] DIR_UNC = 2'b00, DIR_SHR = 2'b01, DIR_MOD = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_SEND, S_WAIT, S_REPLY} state_t;

   state_t                state_q, state_d;
   logic [1:0]            rtype_q;
   logic [NODE_W-1:0]     rnode_q;
   logic [LINE_W-1:0]     rline_q;
   logic [1:0]            mtype_q, ptype_q, nst_q;
   logic [NUM_NODES-1:0]  mtgt_q, nsh_q;
   logic                  perr_q;
   logic [1:0]            dir_st_q [NUM_LINES];
   logic [NUM_NODES-1:0]  dir_sh_q [NUM_LINES];

   logic [1:0]            cur_st, dec_mtype, dec_ptype, dec_nst;
   logic [NUM_NODES-1:0]  cur_sh, req_bit, dec_mtgt, dec_nsh;
   logic                  wb_ok, wb_bad;

`ifdef DIR_INV_ACK_EN
   localparam int CNT_W = $clog2(NUM_NODES + 1);
   logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d, ack_load;

   always_comb begin
      ack_load = '0;
      for (int i = 0; i < NUM_NODES; i++) ack_load = ack_load + CNT_W'(mtgt_q[i]);
      ack_load = ack_load - CNT_W'(invAck);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ack_cnt_q <= '0;
      else        ack_cnt_q <= ack_cnt_d;
   end
`else
   logic unused_inv_ack;
   assign unused_inv_ack = invAck;
`endif

   // In MODIFIED the sharer vector is one-hot, so owner == requester iff its bit is set.
   always_comb begin
      cur_st    = dir_st_q[rline_q];
      cur_sh    = dir_sh_q[rline_q];
      req_bit   = NUM_NODES'(1) << rnode_q;
      dec_mtype = MSG_INV;
      dec_mtgt  = '0;
      dec_ptype = RP_DATA;
      dec_nst   = cur_st;
      dec_nsh   = cur_sh;
      wb_ok     = 1'b0;
      wb_bad    = 1'b0;
      if (rtype_q == RQ_WB) begin
         if (cur_st == DIR_MOD && cur_sh == req_bit) wb_ok  = 1'b1;
         else                                        wb_bad = 1'b1;
      end else begin
         case (cur_st)
            DIR_SHR: begin
               if (rtype_q == RQ_READ) begin
                  dec_nsh = cur_sh | req_bit;
               end else begin
                  dec_mtgt  = cur_sh & ~req_bit;
                  dec_ptype = (rtype_q == RQ_INV && |(cur_sh & req_bit)) ? RP_UPG : RP_DATA;
                  dec_nst   = DIR_MOD;
                  dec_nsh   = req_bit;
               end
            end
            DIR_MOD: begin
               if (!(|(cur_sh & req_bit))) begin
                  dec_mtgt = cur_sh;
                  if (rtype_q == RQ_READ) begin
                     dec_mtype = MSG_FETCH;
                     dec_nst   = DIR_SHR;
                     dec_nsh   = cur_sh | req_bit;
                  end else begin
                     dec_mtype = MSG_FETCH_INV;
                     dec_nsh   = req_bit;
                  end
               end
            end
            default: begin
               dec_nst = (rtype_q == RQ_READ) ? DIR_SHR : DIR_MOD;
               dec_nsh = req_bit;
            end
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
`ifdef DIR_INV_ACK_EN
      ack_cnt_d = ack_cnt_q;
`endif
      case (state_q)
         S_IDLE:   if (reqValid) state_d = S_LOOKUP;
         S_LOOKUP: begin
            if (wb_ok || wb_bad)   state_d = S_IDLE;
            else if (|dec_mtgt)    state_d = S_SEND;
            else                   state_d = S_REPLY;
         end
         S_SEND: begin
            if (msgReady) begin
               if (mtype_q == MSG_INV) begin
`ifdef DIR_INV_ACK_EN
                  ack_cnt_d = ack_load;
                  state_d   = (ack_load == '0) ? S_REPLY : S_WAIT;
`else
                  state_d = S_REPLY;
`endif
               end else begin
                  state_d = fetchDone ? S_REPLY : S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mtype_q == MSG_INV) begin
`ifdef DIR_INV_ACK_EN
               if (invAck) begin
                  ack_cnt_d = ack_cnt_q - CNT_W'(1);
                  if (ack_cnt_q == CNT_W'(1)) state_d = S_REPLY;
               end
`else
               state_d = S_REPLY;
`endif
            end else if (fetchDone) begin
               state_d = S_REPLY;
            end
         end
         S_REPLY:  if (replyReady) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rtype_q <= '0;
         rnode_q <= '0;
         rline_q <= '0;
         mtype_q <= '0;
         mtgt_q  <= '0;
         ptype_q <= '0;
         nst_q   <= '0;
         nsh_q   <= '0;
         perr_q  <= 1'b0;
         for (int i = 0; i < NUM_LINES; i++) begin
            dir_st_q[i] <= DIR_UNC;
            dir_sh_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         perr_q  <= (state_q == S_LOOKUP) && wb_bad;
         if (state_q == S_IDLE && reqValid) begin
            rtype_q <= reqType;
            rnode_q <= reqNode;
            rline_q <= reqLine;
         end
         if (state_q == S_LOOKUP) begin
            mtype_q <= dec_mtype;
            mtgt_q  <= dec_mtgt;
            ptype_q <= dec_ptype;
            nst_q   <= dec_nst;
            nsh_q   <= dec_nsh;
            if (wb_ok) begin
               dir_st_q[rline_q] <= DIR_UNC;
               dir_sh_q[rline_q] <= '0;
            end
         end
         if (state_q == S_REPLY && replyReady) begin
            dir_st_q[rline_q] <= nst_q;
            dir_sh_q[rline_q] <= nsh_q;
         end
      end
   end

   assign reqReady   = (state_q == S_IDLE);
   assign msgValid   = (state_q == S_SEND);
   assign msgType    = msgValid ? mtype_q : '0;
   assign msgTargets = msgValid ? mtgt_q  : '0;
   assign msgLine    = msgValid ? rline_q : '0;
   assign replyValid = (state_q == S_REPLY);
   assign replyType  = replyValid ? ptype_q : '0;
   assign replyNode  = replyValid ? rnode_q : '0;
   assign replyLine  = replyValid ? rline_q : '0;
   assign protoError = perr_q;

endmodule

// File: tb/tb_directory_controller.sv
// Bench for directory_controller: directed scenarios plus random traffic against a
// line-state/owner model; DIR_INV_ACK_EN selects the ack-counting expectations.
`timescale 1ns/1ps
module tb_directory_controller;
   localparam int NN = 4;
   localparam int NL = 16;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       reqValid = 1'b0, reqReady;
   logic [1:0] reqType = '0;
   logic [1:0] reqNode = '0;
   logic [3:0] reqLine = '0;
   logic       msgValid, msgReady = 1'b0;
   logic [1:0] msgType;
   logic [3:0] msgTargets, msgLine;
   logic       fetchDone = 1'b0, invAck = 1'b0;
   logic       replyValid, replyReady = 1'b0;
   logic [1:0] replyType, replyNode;
   logic [3:0] replyLine;
   logic       protoError;

   always #5 clk = ~clk;

   directory_controller #(.NUM_NODES(NN), .NUM_LINES(NL)) dut (
      .clk(clk), .rst_n(rst_n),
      .reqValid(reqValid), .reqReady(reqReady), .reqType(reqType), .reqNode(reqNode), .reqLine(reqLine),
      .msgValid(msgValid), .msgReady(msgReady), .msgType(msgType), .msgTargets(msgTargets), .msgLine(msgLine),
      .fetchDone(fetchDone), .invAck(invAck),
      .replyValid(replyValid), .replyReady(replyReady), .replyType(replyType), .replyNode(replyNode),
      .replyLine(replyLine), .protoError(protoError));

   int total = 0, bad = 0;

   // model: line state 0=UNCACHED 1=SHARED 2=MODIFIED, sharer vector
   int         m_st [NL];
   logic [3:0] m_sh [NL];
   bit         ex_msg, ex_reply;
   logic [1:0] ex_mtype, ex_rtype;
   logic [3:0] ex_tgt;
   int         ex_perr;

   bit         ob_msg, ob_timeout, ob_hold_err, ob_end_idle;
   logic [1:0] ob_mtype, ob_rtype, ob_rnode;
   logic [3:0] ob_tgt, ob_mline, ob_rline;
   int         ob_perr, ob_rlat, ob_macc_c, ob_fd_c, ob_ack_c;

   function automatic int owner_of(logic [3:0] s);
      for (int i = 0; i < NN; i++) if (s == 4'(1 << i)) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NL; i++) begin m_st[i] = 0; m_sh[i] = '0; end
   endtask

   task automatic model_step(input logic [1:0] t, input int node, input int line);
      int         st  = m_st[line];
      logic [3:0] s   = m_sh[line];
      logic [3:0] r   = 4'(1 << node);
      int         own = owner_of(s);
      ex_msg = 0; ex_reply = 1; ex_mtype = 2'b00; ex_tgt = '0; ex_rtype = 2'b01; ex_perr = 0;
      if (t == 2'b11) begin
         ex_reply = 0;
         if (st == 2 && own == node) begin m_st[line] = 0; m_sh[line] = '0; end
         else ex_perr = 1;
      end else if (st == 0) begin
         m_st[line] = (t == 2'b00) ? 1 : 2;
         m_sh[line] = r;
      end else if (st == 1) begin
         if (t == 2'b00) m_sh[line] = s | r;
         else begin
            ex_tgt = s & ~r; ex_msg = (ex_tgt != 0); ex_mtype = 2'b10;
            if (t == 2'b10 && s[node]) ex_rtype = 2'b10;
            m_st[line] = 2; m_sh[line] = r;
         end
      end else if (own != node) begin
         ex_msg = 1; ex_tgt = 4'(1 << own);
         if (t == 2'b00) begin ex_mtype = 2'b01; m_st[line] = 1; m_sh[line] = ex_tgt | r; end
         else begin ex_mtype = 2'b11; m_st[line] = 2; m_sh[line] = r; end
      end
   endtask

   // Issues one request at the current negedge and plays the remote side; cycle c=0 is the accept cycle.
   task automatic run_txn(input logic [1:0] t, input int node, input int line,
                          input int mhold, input int flat, input int rhold, input bit exp_rep);
      int c, mh, rh, fcnt, acks, racc_c;
      bit macc;
      ob_msg = 0; ob_mtype = '0; ob_tgt = '0; ob_mline = '0; ob_rtype = '0; ob_rnode = '0; ob_rline = '0;
      ob_perr = 0; ob_rlat = -1; ob_macc_c = -1; ob_fd_c = -1; ob_ack_c = -1; ob_hold_err = 0; ob_timeout = 0;
      mh = mhold; rh = rhold; fcnt = -1; acks = 0; racc_c = -1; macc = 0;
      reqValid = 1'b1; reqType = t; reqNode = 2'(node); reqLine = 4'(line);
      @(negedge clk);
      reqValid = 1'b0; reqType = 2'($urandom); reqNode = 2'($urandom); reqLine = 4'($urandom);
      c = 1;
      forever begin
         if (racc_c >= 0 && c > racc_c) break;
         if (!exp_rep && c >= 5) break;
         if (c >= 200) begin ob_timeout = 1; break; end
         msgReady = 1'b0; fetchDone = 1'b0; replyReady = 1'b0;
`ifdef DIR_INV_ACK_EN
         invAck = 1'b0;
`else
         invAck = 1'($urandom_range(0, 1));
`endif
         if (protoError) ob_perr++;
         if (msgValid) begin
            if (!ob_msg) begin ob_msg = 1; ob_mtype = msgType; ob_tgt = msgTargets; ob_mline = msgLine; end
            if (reqReady || macc) ob_hold_err = 1;
            if (mh > 0) mh--;
            else begin msgReady = 1'b1; macc = 1; ob_macc_c = c; fcnt = flat; acks = $countones(ob_tgt); end
         end else if (ob_msg && !macc) ob_hold_err = 1;
         if (macc && ob_mtype != 2'b10) begin
            if (fcnt == 0) begin fetchDone = 1'b1; ob_fd_c = c; fcnt = -1; end
            else if (fcnt > 0) fcnt--;
         end
`ifdef DIR_INV_ACK_EN
         if (macc && ob_mtype == 2'b10 && acks > 0 && $urandom_range(0, 2) != 0) begin
            invAck = 1'b1; acks--;
            if (acks == 0) ob_ack_c = c;
         end
`endif
         if (replyValid) begin
            if (ob_rlat < 0) begin ob_rlat = c; ob_rtype = replyType; ob_rnode = replyNode; ob_rline = replyLine; end
            if (reqReady) ob_hold_err = 1;
            if (rh > 0) rh--;
            else begin replyReady = 1'b1; racc_c = c; end
         end else if (ob_rlat >= 0) ob_hold_err = 1;
         @(negedge clk);
         c++;
      end
      msgReady = 1'b0; fetchDone = 1'b0; replyReady = 1'b0; invAck = 1'b0;
      ob_end_idle = reqReady && !msgValid && !replyValid;
      if (exp_rep && racc_c < 0) ob_timeout = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL reset_reqReady got=%b want=1", reqReady); end
      total++; if ({msgValid, replyValid, protoError} !== 3'b000) begin bad++; $display("FAIL reset_valids got=%b want=000", {msgValid, replyValid, protoError}); end
      total++; if ({msgTargets, msgType, replyType} !== 8'h00) begin bad++; $display("FAIL reset_fields got=%h want=00", {msgTargets, msgType, replyType}); end
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL post_reset_reqReady got=%b want=1", reqReady); end
   endtask

   task automatic test_read_miss();
      model_step(2'b00, 1, 3); run_txn(2'b00, 1, 3, 0, 0, 0, 1);
      total++; if (ob_msg !== 1'b0) begin bad++; $display("FAIL rm_msg got=%b want=0", ob_msg); end
      total++; if (ob_rlat !== 2) begin bad++; $display("FAIL rm_latency got=%0d want=2", ob_rlat); end
      total++; if (ob_rtype !== 2'b01) begin bad++; $display("FAIL rm_type got=%b want=01", ob_rtype); end
      total++; if ({ob_rnode, ob_rline} !== {2'd1, 4'd3}) begin bad++; $display("FAIL rm_dest got=%0d/%0d want=1/3", ob_rnode, ob_rline); end
      total++; if (ob_end_idle !== 1'b1) begin bad++; $display("FAIL rm_idle got=%b want=1", ob_end_idle); end
   endtask

   task automatic test_write_inv();
      model_step(2'b00, 0, 3); run_txn(2'b00, 0, 3, 0, 0, 0, 1);
      total++; if (ob_msg !== 1'b0) begin bad++; $display("FAIL shr_rm_msg got=%b want=0", ob_msg); end
      model_step(2'b01, 2, 3); run_txn(2'b01, 2, 3, 0, 0, 0, 1);
      total++; if ({ob_msg, ob_mtype} !== 3'b110) begin bad++; $display("FAIL wm_inv_type got=%b want=110", {ob_msg, ob_mtype}); end
      total++; if (ob_tgt !== 4'b0011) begin bad++; $display("FAIL wm_inv_targets got=%b want=0011", ob_tgt); end
      total++; if (ob_mline !== 4'd3) begin bad++; $display("FAIL wm_inv_line got=%0d want=3", ob_mline); end
      total++; if ({ob_rtype, ob_rnode} !== {2'b01, 2'd2}) begin bad++; $display("FAIL wm_reply got=%b/%0d want=01/2", ob_rtype, ob_rnode); end
      model_step(2'b00, 1, 3); run_txn(2'b00, 1, 3, 0, 1, 0, 1);
      total++; if ({ob_mtype, ob_tgt} !== {2'b01, 4'b0100}) begin bad++; $display("FAIL wm_owner_fetch got=%b/%b want=01/0100", ob_mtype, ob_tgt); end
   endtask

   task automatic test_fetch();
      model_step(2'b01, 0, 5); run_txn(2'b01, 0, 5, 0, 0, 0, 1);
      model_step(2'b00, 3, 5); run_txn(2'b00, 3, 5, 0, 4, 0, 1);
      total++; if ({ob_mtype, ob_tgt} !== {2'b01, 4'b0001}) begin bad++; $display("FAIL fetch_msg got=%b/%b want=01/0001", ob_mtype, ob_tgt); end
      total++; if (ob_macc_c !== 2) begin bad++; $display("FAIL fetch_send_cycle got=%0d want=2", ob_macc_c); end
      total++; if (ob_rlat !== 7) begin bad++; $display("FAIL fetch_reply_cycle got=%0d want=7", ob_rlat); end
      total++; if ({ob_rtype, ob_rnode} !== {2'b01, 2'd3}) begin bad++; $display("FAIL fetch_reply got=%b/%0d want=01/3", ob_rtype, ob_rnode); end
      model_step(2'b01, 1, 5); run_txn(2'b01, 1, 5, 0, 0, 0, 1);
      total++; if ({ob_mtype, ob_tgt} !== {2'b10, 4'b1001}) begin bad++; $display("FAIL fetch_sharers got=%b/%b want=10/1001", ob_mtype, ob_tgt); end
   endtask

   task automatic test_fetch_coincident();
      model_step(2'b10, 2, 5); run_txn(2'b10, 2, 5, 0, 0, 0, 1);
      total++; if ({ob_mtype, ob_tgt} !== {2'b11, 4'b0010}) begin bad++; $display("FAIL fetchinv_msg got=%b/%b want=11/0010", ob_mtype, ob_tgt); end
      total++; if (ob_rlat !== 3) begin bad++; $display("FAIL fetch_coincident_cycle got=%0d want=3", ob_rlat); end
      total++; if (ob_rtype !== 2'b01) begin bad++; $display("FAIL fetchinv_reply got=%b want=01", ob_rtype); end
   endtask

   task automatic test_write_back();
      model_step(2'b01, 0, 6); run_txn(2'b01, 0, 6, 0, 0, 0, 1);
      model_step(2'b11, 0, 6); run_txn(2'b11, 0, 6, 0, 0, 0, 0);
      total++; if ({ob_msg, ob_rlat == -1, ob_perr} !== {1'b0, 1'b1, 32'd0}) begin bad++; $display("FAIL wb_owner got=msg%b reply%0d perr%0d want=msg0 reply-1 perr0", ob_msg, ob_rlat, ob_perr); end
      model_step(2'b11, 2, 6); run_txn(2'b11, 2, 6, 0, 0, 0, 0);
      total++; if (ob_perr !== 1) begin bad++; $display("FAIL wb_illegal_perr got=%0d want=1", ob_perr); end
      total++; if (ob_rlat !== -1) begin bad++; $display("FAIL wb_illegal_reply got=%0d want=-1", ob_rlat); end
      model_step(2'b00, 1, 6); run_txn(2'b00, 1, 6, 0, 0, 0, 1);
      total++; if ({ob_msg, ob_rlat} !== {1'b0, 32'd2}) begin bad++; $display("FAIL wb_uncached got=msg%b lat%0d want=msg0 lat2", ob_msg, ob_rlat); end
   endtask

   task automatic test_backpressure();
      model_step(2'b01, 0, 12); run_txn(2'b01, 0, 12, 0, 0, 0, 1);
      model_step(2'b01, 3, 12); run_txn(2'b01, 3, 12, 5, 0, 5, 1);
      total++; if ({ob_mtype, ob_tgt} !== {2'b11, 4'b0001}) begin bad++; $display("FAIL bp_msg got=%b/%b want=11/0001", ob_mtype, ob_tgt); end
      total++; if (ob_macc_c !== 7) begin bad++; $display("FAIL bp_msg_accept got=%0d want=7", ob_macc_c); end
      total++; if (ob_rlat !== 8) begin bad++; $display("FAIL bp_reply_cycle got=%0d want=8", ob_rlat); end
      total++; if (ob_hold_err !== 1'b0) begin bad++; $display("FAIL bp_hold got=%b want=0", ob_hold_err); end
      total++; if ({ob_end_idle, ob_timeout} !== 2'b10) begin bad++; $display("FAIL bp_end got=%b want=10", {ob_end_idle, ob_timeout}); end
   endtask

   task automatic test_upgrade();
      for (int n = 0; n < NN; n++) begin model_step(2'b00, n, 7); run_txn(2'b00, n, 7, 0, 0, 0, 1); end
      model_step(2'b10, 0, 7); run_txn(2'b10, 0, 7, 1, 0, 0, 1);
      total++; if ({ob_mtype, ob_tgt} !== {2'b10, 4'b1110}) begin bad++; $display("FAIL upg_msg got=%b/%b want=10/1110", ob_mtype, ob_tgt); end
      total++; if (ob_rtype !== 2'b10) begin bad++; $display("FAIL upg_reply got=%b want=10", ob_rtype); end
`ifdef DIR_INV_ACK_EN
      total++; if (ob_rlat !== ob_ack_c + 1 || ob_ack_c < 0) begin bad++; $display("FAIL upg_ack_wait got=%0d want=%0d", ob_rlat, ob_ack_c + 1); end
`else
      total++; if (ob_rlat !== 4) begin bad++; $display("FAIL upg_reply_cycle got=%0d want=4", ob_rlat); end
`endif
   endtask

   task automatic test_reset_abort();
      model_step(2'b01, 1, 9); run_txn(2'b01, 1, 9, 0, 0, 0, 1);
      reqValid = 1'b1; reqType = 2'b00; reqNode = 2'd2; reqLine = 4'd9;
      @(negedge clk);
      reqValid = 1'b0;
      @(negedge clk);
      total++; if (msgValid !== 1'b1) begin bad++; $display("FAIL abort_send got=%b want=1", msgValid); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({msgValid, reqReady} !== 2'b01) begin bad++; $display("FAIL abort_async got=%b want=01", {msgValid, reqReady}); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      model_step(2'b00, 3, 9); run_txn(2'b00, 3, 9, 0, 0, 0, 1);
      total++; if ({ob_msg, ob_rlat} !== {1'b0, 32'd2}) begin bad++; $display("FAIL abort_line9 got=msg%b lat%0d want=msg0 lat2", ob_msg, ob_rlat); end
      model_step(2'b01, 0, 3); run_txn(2'b01, 0, 3, 0, 0, 0, 1);
      total++; if (ob_msg !== 1'b0) begin bad++; $display("FAIL abort_line3 got=%b want=0", ob_msg); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 250; i++) begin
         logic [1:0] t;
         int node, line, want_lat;
         line = 8 + $urandom_range(0, 3);
         t    = 2'($urandom);
         node = $urandom_range(0, NN - 1);
         if (t == 2'b11 && m_st[line] == 2 && $urandom_range(0, 1) == 1) node = owner_of(m_sh[line]);
         model_step(t, node, line);
         run_txn(t, node, line, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3), ex_reply);
         total++; if (ob_msg !== ex_msg) begin bad++; $display("FAIL rnd%0d msg got=%b want=%b", i, ob_msg, ex_msg); end
         if (ex_msg && ob_msg) begin
            total++; if ({ob_mtype, ob_tgt, ob_mline} !== {ex_mtype, ex_tgt, 4'(line)}) begin bad++; $display("FAIL rnd%0d msgfields got=%b/%b/%0d want=%b/%b/%0d", i, ob_mtype, ob_tgt, ob_mline, ex_mtype, ex_tgt, line); end
         end
         total++; if ((ob_rlat >= 0) !== ex_reply) begin bad++; $display("FAIL rnd%0d reply_present got=%b want=%b", i, ob_rlat >= 0, ex_reply); end
         if (ex_reply && ob_rlat >= 0) begin
            total++; if ({ob_rtype, ob_rnode, ob_rline} !== {ex_rtype, 2'(node), 4'(line)}) begin bad++; $display("FAIL rnd%0d replyfields got=%b/%0d/%0d want=%b/%0d/%0d", i, ob_rtype, ob_rnode, ob_rline, ex_rtype, node, line); end
            if (!ex_msg) want_lat = 2;
            else if (ex_mtype != 2'b10) want_lat = ob_fd_c + 1;
`ifdef DIR_INV_ACK_EN
            else want_lat = ob_ack_c + 1;
`else
            else want_lat = ob_macc_c + 1;
`endif
            total++; if (ob_rlat !== want_lat || want_lat < 2) begin bad++; $display("FAIL rnd%0d reply_cycle got=%0d want=%0d", i, ob_rlat, want_lat); end
         end
         total++; if (ob_perr !== ex_perr) begin bad++; $display("FAIL rnd%0d protoError got=%0d want=%0d", i, ob_perr, ex_perr); end
         total++; if ({ob_hold_err, ob_end_idle, ob_timeout} !== 3'b010) begin bad++; $display("FAIL rnd%0d handshake got=%b want=010", i, {ob_hold_err, ob_end_idle, ob_timeout}); end
         if (ob_timeout) break;
      end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_write_inv();
      test_fetch();
      test_fetch_coincident();
      test_write_back();
      test_backpressure();
      test_upgrade();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
